// File: rtl/riscv_pkg.sv
// riscv_pkg: shared types and constants for the RV32I core front end.
//   XLEN          - architectural register / address width
//   NOP_INSTR     - addi x0,x0,0, used as the pipeline bubble encoding
//   fetch_state_t - instruction-fetch controller states
//   if_id_t       - contents of the IF/ID pipeline register
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_FULL
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            valid;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// if_id_reg: IF/ID pipeline register with flush, hold and load controls.
// Ports:
//   clk       - core clock
//   rst       - asynchronous active-low reset
//   stall     - hold current contents
//   flush     - force a bubble (wins over stall)
//   load      - take load_data this cycle (when not stalled/flushed)
//   load_data - {instr, pc, valid} to load
//   q         - current register contents
// A bubble replaces the instruction with BUBBLE_INSTR and clears valid but
// leaves pc untouched, so id_pc keeps pointing at the last real instruction.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] BUBBLE_INSTR = NOP_INSTR
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   stall,
  input  logic   flush,
  input  logic   load,
  input  if_id_t load_data,
  output if_id_t q
);

  if_id_t q_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_reg.instr <= BUBBLE_INSTR;
      q_reg.pc    <= '0;
      q_reg.valid <= 1'b0;
    end else if (flush) begin
      q_reg.instr <= BUBBLE_INSTR;
      q_reg.valid <= 1'b0;
    end else if (!stall) begin
      if (load) begin
        q_reg <= load_data;
      end else begin
        q_reg.instr <= BUBBLE_INSTR;
        q_reg.valid <= 1'b0;
      end
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction fetch plus IF/ID register.
// Ports:
//   clk, rst (async active-low)
//   if_stall               - hazard unit hold of IF/ID and PC
//   redirect_valid/_pc     - EX branch/jump target (pc bits [1:0] ignored)
//   imem_req/imem_addr     - one-cycle request pulse and its word address
//   imem_rvalid/imem_rdata - response strobe and instruction word
//   id_instr, id_pc, id_pc_plus4, id_valid, id_flush - IF/ID outputs
// One request is outstanding at most. A word that returns while decode is
// stalled is parked in a one-entry skid buffer. A redirect that arrives
// while a request is still in flight sets a discard flag so the stale word
// is dropped when it eventually returns.
module fetch_stage
  import riscv_pkg::XLEN, riscv_pkg::if_id_t, riscv_pkg::fetch_state_t,
         riscv_pkg::S_IDLE, riscv_pkg::S_REQ, riscv_pkg::S_WAIT, riscv_pkg::S_FULL;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_pc_plus4,
  output logic            id_valid,
  output logic            id_flush
);

  fetch_state_t    state_q, state_n;
  logic [XLEN-1:0] pc_q, pc_n;
  logic            discard_q, discard_n;
  if_id_t          skid_q, skid_n;
  logic            load;
  if_id_t          load_data;
  if_id_t          if_id;

  // Targets are word aligned; the low bits of redirect_pc carry no meaning.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      discard_q <= 1'b0;
      skid_q    <= '0;
    end else begin
      state_q   <= state_n;
      pc_q      <= pc_n;
      discard_q <= discard_n;
      skid_q    <= skid_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    pc_n      = pc_q;
    discard_n = discard_q;
    skid_n    = skid_q;
    load      = 1'b0;
    load_data = '0;

    if (redirect_valid) begin
      pc_n         = {redirect_pc[XLEN-1:2], 2'b00};
      skid_n.valid = 1'b0;
      case (state_q)
        // The request issued this cycle will still return: mark it stale.
        S_REQ: begin
          discard_n = 1'b1;
          state_n   = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            discard_n = 1'b0;
            state_n   = S_REQ;
          end else begin
            discard_n = 1'b1;
          end
        end
        default: state_n = S_REQ;
      endcase
    end else begin
      case (state_q)
        S_IDLE: state_n = S_REQ;
        S_REQ:  state_n = S_WAIT;
        S_WAIT: begin
          if (imem_rvalid) begin
            if (discard_q) begin
              discard_n = 1'b0;
              state_n   = S_REQ;
            end else if (!if_stall) begin
              load      = 1'b1;
              load_data = '{instr: imem_rdata, pc: pc_q, valid: 1'b1};
              pc_n      = pc_q + 32'd4;
              state_n   = S_REQ;
            end else begin
              skid_n  = '{instr: imem_rdata, pc: pc_q, valid: 1'b1};
              state_n = S_FULL;
            end
          end
        end
        S_FULL: begin
          if (!if_stall) begin
            load         = 1'b1;
            load_data    = skid_q;
            skid_n.valid = 1'b0;
            pc_n         = pc_q + 32'd4;
            state_n      = S_REQ;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  if_id_reg #(
    .BUBBLE_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk      (clk),
    .rst      (rst),
    .stall    (if_stall),
    .flush    (redirect_valid),
    .load     (load),
    .load_data(load_data),
    .q        (if_id)
  );

  // Request depends on state only, so memory-side inputs never loop back.
  assign imem_req    = (state_q == S_REQ);
  assign imem_addr   = pc_q;
  assign id_instr    = if_id.instr;
  assign id_pc       = if_id.pc;
  assign id_pc_plus4 = if_id.pc + 32'd4;
  assign id_valid    = if_id.valid;
  assign id_flush    = ~if_id.valid;

endmodule
